// File: rtl/seq_alu_pkg.sv
// Shared types for seq_alu: opcode and FSM state enums, iterator cycle count.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_NOT  = 4'h2,
    OP_SLL  = 4'h3,
    OP_SRL  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_SLT  = 4'h7,
    OP_BEQ  = 4'h8,
    OP_BNE  = 4'h9,
    OP_BLT  = 4'hA,
    OP_BGE  = 4'hB,
    OP_MUL  = 4'hC,
    OP_DIVU = 4'hD,
    OP_SRA  = 4'hE,
    OP_RSVD = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  function automatic int unsigned MULDIV_CYCLES(input int unsigned width);
    return width;
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
// lo/hi present the value of the current step, so they are final while done is high.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int unsigned LAST = MULDIV_CYCLES(WIDTH) - 1;
  localparam int unsigned CW   = $clog2(MULDIV_CYCLES(WIDTH));

  logic [WIDTH-1:0] acc, acc_n, sh, sh_n, opd;
  logic [WIDTH:0]   sum, trial;
  logic             div_q;
  logic [CW-1:0]    cnt;

  // acc holds the high product / partial remainder; sh holds multiplier / quotient bits
  always_comb begin
    sum   = '0;
    trial = '0;
    acc_n = acc;
    sh_n  = sh;
    if (div_q) begin
      trial = {acc, sh[WIDTH-1]} - {1'b0, opd};
      if (!trial[WIDTH]) begin
        acc_n = trial[WIDTH-1:0];
        sh_n  = {sh[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = {acc[WIDTH-2:0], sh[WIDTH-1]};
        sh_n  = {sh[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum   = {1'b0, acc} + {1'b0, opd & {WIDTH{sh[0]}}};
      acc_n = sum[WIDTH:1];
      sh_n  = {sum[0], sh[WIDTH-1:1]};
    end
  end

  assign done = busy && (cnt == CW'(LAST));
  assign lo   = sh_n;
  assign hi   = acc_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      sh    <= '0;
      opd   <= '0;
      div_q <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      acc   <= '0;
      sh    <= a;
      opd   <= b;
      div_q <= is_div;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      acc <= acc_n;
      sh  <= sh_n;
      if (done) busy <= 1'b0;
      else      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle logic/arith/branch ops plus iterative MUL/DIVU.
// Define SEQ_ALU_MULDIV_EN to compile in the multiply/divide iterator.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             taken,
  output logic             err
);

  state_e           state_q, state_n;
  op_e              opc;
  logic [WIDTH-1:0] sc_res, sc_hi, res_q, hi_q;
  logic             sc_taken, sc_err, taken_q, err_q;
  logic             accept, load_sc, lt;

  assign opc    = op_e'(op);
  assign accept = in_valid && in_ready;
  assign lt     = $signed(a) < $signed(b);

  always_comb begin
    sc_res   = '0;
    sc_hi    = '0;
    sc_taken = 1'b0;
    sc_err   = 1'b0;
    case (opc)
      OP_ADD:  sc_res = a + b;
      OP_SUB:  sc_res = a - b;
      OP_NOT:  sc_res = ~a;
      OP_SLL:  sc_res = a << shamt;
      OP_SRL:  sc_res = a >> shamt;
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, lt};
      OP_BEQ:  begin sc_res = a - b; sc_taken = (a == b); end
      OP_BNE:  begin sc_res = a - b; sc_taken = (a != b); end
      OP_BLT:  begin sc_res = a - b; sc_taken = lt;       end
      OP_BGE:  begin sc_res = a - b; sc_taken = !lt;      end
      OP_SRA:  sc_res = $signed(a) >>> shamt;
`ifdef SEQ_ALU_MULDIV_EN
      OP_MUL:  sc_res = '0;
      // Only divide-by-zero completes here; other divides go to the iterator
      OP_DIVU: if (b == '0) begin sc_res = '1; sc_hi = a; sc_err = 1'b1; end
`endif
      default: sc_err = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  logic             md_start, md_busy, md_done, iter_op, load_md;
  logic [WIDTH-1:0] md_lo, md_hi;

  assign iter_op = (opc == OP_MUL) || (opc == OP_DIVU && b != '0);

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .is_div (opc == OP_DIVU),
    .a      (a),
    .b      (b),
    .busy   (md_busy),
    .done   (md_done),
    .lo     (md_lo),
    .hi     (md_hi)
  );

  assign in_ready = ((state_q == ST_IDLE) || (state_q == ST_DONE && out_ready)) && !md_busy;
`else
  assign in_ready = (state_q == ST_IDLE) || (state_q == ST_DONE && out_ready);
`endif

  always_comb begin
    state_n = state_q;
    load_sc = 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
    md_start = 1'b0;
    load_md  = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
`ifdef SEQ_ALU_MULDIV_EN
          if (iter_op) begin
            md_start = 1'b1;
            state_n  = ST_BUSY;
          end else begin
            load_sc = 1'b1;
            state_n = ST_DONE;
          end
`else
          load_sc = 1'b1;
          state_n = ST_DONE;
`endif
        end else if (state_q == ST_DONE && out_ready) begin
          state_n = ST_IDLE;
        end
      end
`ifdef SEQ_ALU_MULDIV_EN
      ST_BUSY: if (md_done) begin
        load_md = 1'b1;
        state_n = ST_DONE;
      end
`endif
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      hi_q    <= '0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      if (load_sc) begin
        res_q   <= sc_res;
        hi_q    <= sc_hi;
        taken_q <= sc_taken;
        err_q   <= sc_err;
      end
`ifdef SEQ_ALU_MULDIV_EN
      else if (load_md) begin
        res_q   <= md_lo;
        hi_q    <= md_hi;
        taken_q <= 1'b0;
        err_q   <= 1'b0;
      end
`endif
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign result    = res_q;
  assign result_hi = hi_q;
  assign zero      = (res_q == '0);
  assign taken     = taken_q;
  assign err       = err_q;

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the datapath ALU. It executes single-cycle logic, arithmetic and branch-compare operations, and iterative multiply and unsigned divide over WIDTH cycles. All operations use a valid/ready interface on both sides. The block sits between the decode/register-read stage and writeback; the pipeline stalls on `in_ready` while a multiply or divide is in flight.

## Interface
- `WIDTH`, 32: operand and result width; must be at least 4.
- `SHW`, $clog2(WIDTH): shift-amount width; derived, not overridden.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  request valid
- `in_ready`  out  1  request accepted when `in_valid && in_ready`
- `op`  in  4  operation code (see Operation)
- `a`, `b`  in  WIDTH  operands
- `shamt`  in  SHW  shift amount
- `out_valid`  out  1  result valid; held until `out_ready`
- `out_ready`  in  1  consumer accepts the result
- `result`  out  WIDTH  primary result (low product, quotient)
- `result_hi`  out  WIDTH  high product or remainder; 0 for other ops
- `zero`  out  1  `result == 0`
- `taken`  out  1  branch condition true (branch ops only, else 0)
- `err`  out  1  illegal op or divide by zero

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 NOT a, 3 SLL a by shamt, 4 SRL, 5 AND, 6 OR, 7 SLT (signed, result 1/0).
  - 8 BEQ, 9 BNE, A BLT (signed), B BGE (signed). For these, result = a−b and `taken` reflects the condition.
  - C MUL (unsigned, 2·WIDTH product split lo/hi), D DIVU (unsigned quotient/remainder), E SRA, F reserved.
- Arithmetic wraps modulo 2^WIDTH. Signed compares use two's complement, not the sign of the difference.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: accept a request. A single-cycle op registers its outputs and goes to DONE. MUL or DIVU loads the iterator and goes to BUSY.
  - BUSY: one shift-add or restoring-subtract step per cycle for WIDTH cycles, then DONE.
  - DONE: `out_valid`=1. On `out_ready`, either accept a new request in the same cycle (going to DONE or BUSY) or go to IDLE.
- `in_ready` = (state==IDLE) || (state==DONE && out_ready). It is 0 throughout BUSY.
- Operands are captured on accept. Input changes afterwards do not affect the result.
- DIVU with b=0: quotient all-ones, remainder = a, `err`=1, completes in 1 cycle.
- Op F: result 0, `err`=1, 1 cycle.
- Outputs are registered and stable while `out_valid && !out_ready`.

## Timing
- Reset values:
  - state IDLE, `in_ready`=1, `out_valid`=0.
  - `result`, `result_hi` = 0; `zero`=1 (it follows `result`); `taken`=0; `err`=0.
- Single-cycle ops: `out_valid` rises on the edge after accept, so latency is 1. Back-to-back throughput is 1/cycle while `out_ready`=1.
- MUL/DIVU: `out_valid` rises WIDTH+1 edges after accept (33 for WIDTH=32). The next request can be accepted no earlier than the DONE cycle.
- Backpressure: with `out_ready`=0 in DONE, `in_ready`=0 and the outputs hold indefinitely.
- Reset mid-BUSY aborts the operation immediately and discards the partial result. No `out_valid` is produced for the aborted op.
- `in_valid` without `in_ready` has no effect.

## Configuration
- `SEQ_ALU_MULDIV_EN` defined: MUL/DIVU and the iterator are compiled in as specified.
- Not defined: the iterator is removed and BUSY is unreachable. Opcodes C and D behave as op F (result 0, `result_hi` 0, `err`=1, latency 1).

## Structure
- Package `seq_alu_pkg` holds:
  - the op enum (`OP_ADD` … `OP_RSVD`) and the state enum (`ST_IDLE`, `ST_BUSY`, `ST_DONE`);
  - the `MULDIV_CYCLES` = WIDTH constant function.
- Sub-module `seq_alu_muldiv`, parametrised by WIDTH:
  - start/busy/done interface; holds the accumulator, operand shift registers and the step counter;
  - instantiated only under `SEQ_ALU_MULDIV_EN`.
- Single-cycle datapath and FSM live in `seq_alu`.

## Test plan
- Reset then ADD a=0xFFFFFFFF b=1 → result 0, `zero`=1, `out_valid` 1 cycle after accept.
- BLT a=0xFFFFFFFE(−2) b=1 → `taken`=1, result 0xFFFFFFFD. BGE with the same operands → `taken`=0.
- MUL a=0x80000000 b=4 → result 0, `result_hi` 2, `out_valid` exactly 33 cycles after accept, `in_ready`=0 throughout.
- DIVU a=100 b=7 → result 14, `result_hi` 2. DIVU a=5 b=0 → result 0xFFFFFFFF, `result_hi` 5, `err`=1, latency 1.
- Backpressure: SLL a=1 shamt=31 with `out_ready`=0 for 5 cycles → result 0x80000000 held stable, `in_ready`=0. Then `out_ready`=1 with a queued AND → accepted in the same cycle.
- Assert `rst_n`=0 at cycle 10 of a MUL → all outputs at reset values, and the next ADD 2+3 yields 5.
